// File: rtl/cap_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cap_sched_pkg                                             |
// | Brief    : Shared types, state encoding, width helper and reset      |
// |            constants for the capture scheduler.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package cap_sched_pkg;

  // Two-state scheduler FSM, kept as plain constants for legacy tools.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_REPORT = 1'b1;

  // Reset values: everything comes up zero / idle.
  localparam state_t RST_STATE = ST_IDLE;
  localparam logic   RST_BIT   = 1'b0;

  // Width of a requester index; never below one bit so ports stay legal.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : cap_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter                                                |
// | Brief    : Round-robin arbiter. Search starts at ptr and ascends     |
// |            with wrap; the first active request wins.                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rr_arbiter
  import cap_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SRC_W = src_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [SRC_W-1:0] gnt_idx
);

  logic             found;
  logic [SRC_W-1:0] idx;
  int               sum;

  // Walk the requesters from ptr upward (modulo N_REQ); grant the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = SRC_W'(sum);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/dff_capture_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dff_capture_scheduler                                     |
// | Brief    : Shares one capture register among N_REQ requesters with   |
// |            round-robin grants, timestamps every capture and emits a  |
// |            one-cycle capture report.                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dff_capture_scheduler
  import cap_sched_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 1,
  parameter  int TS_W   = 16,
  localparam int SRC_W  = src_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    hold,
  output logic [DATA_W-1:0]       q,
  output logic                    cap_valid,
  output logic [SRC_W-1:0]        cap_src,
  output logic [TS_W-1:0]         cap_time
);

  state_t           state;
  logic [TS_W-1:0]  ts;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] ptr_nxt;
  logic [N_REQ-1:0] gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic             arb_en;
  logic             grant;
  logic [DATA_W-1:0] lanes [N_REQ];
  int               nxt_sum;

  // Unpack the flat data bus into one lane per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lanes[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Grants are offered only in IDLE, outside reset and while not paused.
  assign arb_en = (state == ST_IDLE) && !hold && !rst;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign grant     = |gnt;
  assign cap_valid = (state == ST_REPORT);

  // Pointer advances to the index just past the winner, wrapping at N_REQ.
  always_comb begin
    nxt_sum = int'(gnt_idx) + 1;
    if (nxt_sum >= N_REQ) nxt_sum = 0;
    ptr_nxt = SRC_W'(nxt_sum);
  end

  // FSM, timestamp counter, round-robin pointer and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      ts       <= '0;
      ptr      <= '0;
      q        <= {DATA_W{RST_BIT}};
      cap_src  <= '0;
      cap_time <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      case (state)
        ST_IDLE: begin
          if (grant) begin
            q        <= lanes[gnt_idx];
            cap_src  <= gnt_idx;
            cap_time <= ts;
            ptr      <= ptr_nxt;
            state    <= ST_REPORT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : dff_capture_scheduler
`default_nettype wire

// File: tb/tb_dff_capture_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dff_capture_scheduler                                  |
// | Brief    : Self-checking bench: directed scenarios plus random       |
// |            traffic compared against a behavioural scheduler model.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_dff_capture_scheduler;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 1;
  localparam int TS_W   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_data;
  logic [3:0]   req_ready;
  logic         hold;
  logic [0:0]   q;
  logic         cap_valid;
  logic [1:0]   cap_src;
  logic [3:0]   cap_time;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state (plain integers, modulo arithmetic).
  int m_ts, m_ptr, m_q, m_src, m_time;
  bit m_busy;

  dff_capture_scheduler #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .TS_W   (TS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .q         (q),
    .cap_valid (cap_valid),
    .cap_src   (cap_src),
    .cap_time  (cap_time)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check grant, clock, update model, check outputs.
  task automatic tick(input logic r, input logic [3:0] v, input logic [3:0] d, input logic h);
    int   win;
    logic [3:0] exp_rdy;
    rst = r; req_valid = v; req_data = d; hold = h;
    win = -1;
    exp_rdy = 4'b0000;
    if (!r && !m_busy && !h) begin
      for (int k = 0; k < N_REQ; k++) begin
        int j;
        j = (m_ptr + k) % N_REQ;
        if (win < 0 && v[j]) win = j;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    #1;
    check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (r) begin
      m_ts = 0; m_ptr = 0; m_q = 0; m_src = 0; m_time = 0; m_busy = 1'b0;
    end else begin
      if (m_busy) begin
        m_busy = 1'b0;
      end else if (win >= 0) begin
        m_q    = d[win];
        m_src  = win;
        m_time = m_ts;
        m_ptr  = (win + 1) % N_REQ;
        m_busy = 1'b1;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    #1;
    check("cap_valid", {31'd0, cap_valid}, {31'd0, m_busy});
    check("q",         {31'd0, q},         32'(m_q));
    check("cap_src",   {30'd0, cap_src},   32'(m_src));
    check("cap_time",  {28'd0, cap_time},  32'(m_time));
    @(negedge clk);
  endtask

  initial begin
    m_ts = 0; m_ptr = 0; m_q = 0; m_src = 0; m_time = 0; m_busy = 1'b0;
    rst = 1'b1; req_valid = '0; req_data = '0; hold = 1'b0;
    @(negedge clk);

    // Reset for 3 cycles, then 5 idle cycles.
    repeat (3) tick(1'b1, 4'b0000, 4'b0000, 1'b0);
    repeat (5) tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("idle_q", {31'd0, q}, 32'd0);
    check("idle_cap_time", {28'd0, cap_time}, 32'd0);

    // Lone requester 2: grant every other cycle, first capture at ts=5.
    tick(1'b0, 4'b0100, 4'b0100, 1'b0);
    check("single_time0", {28'd0, cap_time}, 32'd5);
    check("single_src0", {30'd0, cap_src}, 32'd2);
    check("single_q0", {31'd0, q}, 32'd1);
    tick(1'b0, 4'b0100, 4'b0100, 1'b0);
    tick(1'b0, 4'b0100, 4'b0100, 1'b0);
    check("single_time1", {28'd0, cap_time}, 32'd7);
    check("single_valid1", {31'd0, cap_valid}, 32'd1);
    tick(1'b0, 4'b0100, 4'b0100, 1'b0);

    // All requesting from pointer 0: order 0,1,2,3,0 with q = i & 1.
    tick(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 4'b1111, 4'b1010, 1'b0);
      check("rr_src", {30'd0, cap_src}, 32'(i % 4));
      check("rr_q", {31'd0, q}, 32'(i & 1));
      tick(1'b0, 4'b1111, 4'b1010, 1'b0);
    end

    // Hold raised during REPORT: report completes, then no grants, then ptr's next.
    tick(1'b0, 4'b1111, 4'b1010, 1'b0);
    check("hold_pre_src", {30'd0, cap_src}, 32'd1);
    tick(1'b0, 4'b1111, 4'b1010, 1'b1);
    check("hold_valid_drop", {31'd0, cap_valid}, 32'd0);
    repeat (3) tick(1'b0, 4'b1111, 4'b1010, 1'b1);
    tick(1'b0, 4'b1111, 4'b1010, 1'b0);
    check("hold_resume_src", {30'd0, cap_src}, 32'd2);
    tick(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Timestamp wrap: capture at ts=15, next capture two cycles later at ts=1.
    tick(1'b1, 4'b0000, 4'b0000, 1'b0);
    repeat (15) tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    tick(1'b0, 4'b0001, 4'b0001, 1'b0);
    check("wrap_time15", {28'd0, cap_time}, 32'd15);
    tick(1'b0, 4'b0001, 4'b0001, 1'b0);
    tick(1'b0, 4'b0001, 4'b0001, 1'b0);
    check("wrap_time1", {28'd0, cap_time}, 32'd1);

    // Reset in the REPORT cycle; pointer back to 0 so requester 1 wins 4'b1010.
    tick(1'b1, 4'b0001, 4'b0001, 1'b0);
    check("rst_rep_valid", {31'd0, cap_valid}, 32'd0);
    check("rst_rep_q", {31'd0, q}, 32'd0);
    tick(1'b0, 4'b1010, 4'b1111, 1'b0);
    check("rst_rep_src", {30'd0, cap_src}, 32'd1);
    tick(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Random traffic with occasional hold and reset.
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_dff_capture_scheduler
`default_nettype wire
